tlb_walker: RTL and testbench
=============================

Name: tlb_walker

Overview:
- Parametrised, fully associative TLB with a miss-handling state machine.
- Generalises the existing fixed 6-bit-VPN / 2-bit-PPN page-translation path: configurable entry count, true-LRU replacement, dirty tracking on stores, flush, and a handshaked page-table walk to the memory model.
- Sits between the CPU request generator and the cache; drives the physical page number into the cache index.

Parameters:
- VPN_W, 6, virtual page number width.
- PPN_W, 2, physical page number width.
- ENTRIES, 4, number of TLB entries; power of two, 2..16.
- AGE_W, $clog2(ENTRIES), LRU age counter width per entry (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  translation request; held stable until resp_valid.
- req_vpn  in  VPN_W  virtual page number.
- req_write  in  1  1 = store (sets dirty), 0 = load.
- flush  in  1  one-cycle pulse; invalidates all entries.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  one-cycle pulse; translation complete.
- resp_ppn  out  PPN_W  physical page number; valid with resp_valid.
- resp_hit  out  1  1 = served from TLB, 0 = served after walk.
- page_fault  out  1  pulses with resp_valid when the walk reports page not present; resp_ppn = 0.
- walk_req  out  1  level-held page-table walk request.
- walk_vpn  out  VPN_W  VPN being walked; registered copy of req_vpn.
- walk_done  in  1  one-cycle pulse from memory; ends the walk.
- walk_present  in  1  page present; valid with walk_done.
- walk_ppn  in  PPN_W  PPN from page table; valid with walk_done.
- dirty_vec  out  ENTRIES  per-entry dirty bits (observation/writeback hint).

Behaviour:
- Reset (async, rst_n=0):
  - all valid, dirty, tag, ppn and age registers cleared;
  - state = IDLE;
  - resp_valid = resp_hit = page_fault = walk_req = 0;
  - resp_ppn = 0, walk_vpn = 0, req_ready = 1.
- States: IDLE, WALK, RESP.
- IDLE, req_valid=1:
  - Hit (valid & tag == req_vpn, combinational compare): next cycle resp_valid=1, resp_hit=1, resp_ppn = entry ppn. Latency 1 cycle. State stays IDLE; req_ready drops for that response cycle.
  - Miss: latch VPN into walk_vpn, assert walk_req, go to WALK.
- WALK:
  - walk_req held high until walk_done.
  - On walk_done with walk_present=1:
    - fill victim with tag = walk_vpn, ppn = walk_ppn, valid=1, dirty = req_write;
    - go to RESP.
  - On walk_done with walk_present=0: no fill; go to RESP with a fault flag.
- RESP:
  - resp_valid=1, resp_hit=0, page_fault = fault flag, resp_ppn = walk_ppn (0 on fault).
  - Return to IDLE.
  - Miss latency = walk cycles + 2.
- Victim selection:
  - lowest-index invalid entry;
  - if all entries are valid, the entry with maximum age; ties go to the lowest index.
- LRU update (every hit or fill of entry k):
  - entries with age < age[k] increment, saturating at ENTRIES-1;
  - age[k] = 0;
  - all other entries unchanged.
- Dirty: store hit sets dirty of the hit entry. Dirty is never cleared except by flush or reset.
- Flush:
  - In IDLE: clears all valid/dirty/age on the next edge; a same-cycle request is treated as a miss.
  - In WALK: the walk completes and its fill still occurs after the flush.
  - flush has priority over a same-cycle hit update.
- Duplicate tags never occur: fills happen only after a miss.
- req_valid deasserted mid-walk: the walk still completes, resp_valid still pulses, the fill still occurs.
- Reset during WALK: walk_req drops immediately (async), no fill, no response.

Optional Feature:
- Macro TLB_STATS_EN.
- Defined:
  - adds 16-bit outputs hit_count and miss_count, reset 0;
  - increment on each hit / walk start, saturating at 16'hFFFF;
  - flush does not clear them.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package vm_pkg:
  - state enum (IDLE, WALK, RESP);
  - default widths VPN_W=6, PPN_W=2;
  - a PTE struct {valid, dirty, tag, ppn}.
- One sub-module, tlb_lru: per-entry age array, hit/fill update, victim index output.
- CAM compare and FSM remain in tlb_walker.

Test Plan:
- Reset then req vpn=6'h01; walk returns present, ppn=2'b10 after 3 cycles -> walk_req high 3 cycles, resp_valid with resp_hit=0, resp_ppn=2; repeat request -> 1-cycle hit, ppn=2.
- Fill vpn 1,2,3,4 (ENTRIES=4), touch 1, then miss on vpn 5 -> victim is vpn 2's entry; subsequent vpn 2 request misses, vpn 1 hits.
- Miss on vpn 6'h07 with walk_present=0 -> page_fault=1, resp_ppn=0, no entry filled; retry vpn 7 walks again.
- Store hit on vpn 3 -> its dirty_vec bit = 1; load hit on vpn 1 -> its dirty bit unchanged (0).
- Flush pulse after 4 fills -> dirty_vec=0, every subsequent request misses; flush during WALK -> fill still lands.
- rst_n low mid-WALK -> walk_req=0 immediately, no resp_valid; with TLB_STATS_EN, hit_count/miss_count read 0 after reset.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared definitions for the virtual-memory translation path.
// Contents: walker state enum, default page-number widths, and the
// page-table-entry layout at those default widths.
package vm_pkg;

  localparam int unsigned VPN_W_DEF = 6;
  localparam int unsigned PPN_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RESP = 2'd2
  } state_e;

  // TLB entry at the default widths; tlb_walker re-declares the same layout
  // with its own VPN_W/PPN_W so the widths follow its parameters.
  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [VPN_W_DEF-1:0] tag;
    logic [PPN_W_DEF-1:0] ppn;
  } pte_t;

endpackage

// File: rtl/tlb_lru.sv
// True-LRU age tracker for a fully associative TLB.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   flush          clears every age
//   upd_en/upd_idx hit or fill of entry upd_idx (becomes most recent)
//   valid_vec      per-entry valid bits from the TLB
//   victim_idx_c   combinational replacement choice
module tlb_lru #(
  parameter  int unsigned ENTRIES = 4,
  localparam int unsigned AGE_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               upd_en,
  input  logic [AGE_W-1:0]   upd_idx,
  input  logic [ENTRIES-1:0] valid_vec,
  output logic [AGE_W-1:0]   victim_idx_c
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(ENTRIES - 1);

  logic [AGE_W-1:0] age_q [ENTRIES];
  logic [AGE_W-1:0] age_d [ENTRIES];
  logic [AGE_W-1:0] ref_age;

  // A fill into an invalid slot counts as the oldest slot becoming newest,
  // so every valid entry ages by one.
  always_comb begin
    age_d   = age_q;
    ref_age = valid_vec[upd_idx] ? age_q[upd_idx] : AGE_MAX;
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) age_d[i] = '0;
    end else if (upd_en) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (AGE_W'(i) == upd_idx) begin
          age_d[i] = '0;
        end else if (valid_vec[i] && (age_q[i] < ref_age) && (age_q[i] != AGE_MAX)) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  // Lowest invalid entry first, otherwise oldest valid (ties to lowest index).
  always_comb begin
    logic             inv_found;
    logic [AGE_W-1:0] inv_idx;
    logic [AGE_W-1:0] max_idx;
    logic [AGE_W-1:0] max_age;
    inv_found = 1'b0;
    inv_idx   = '0;
    max_idx   = '0;
    max_age   = age_q[0];
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        inv_found = 1'b1;
        inv_idx   = AGE_W'(i);
      end
    end
    for (int i = 1; i < ENTRIES; i++) begin
      if (age_q[i] > max_age) begin
        max_age = age_q[i];
        max_idx = AGE_W'(i);
      end
    end
    victim_idx_c = inv_found ? inv_idx : max_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= '0;
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/tlb_walker.sv
// Fully associative TLB with page-table-walk miss handling.
// Ports:
//   req_valid/req_vpn/req_write/req_ready   CPU translation request
//   resp_valid/resp_ppn/resp_hit/page_fault translation response (1-cycle pulse)
//   walk_req/walk_vpn                       page-table walk request to memory
//   walk_done/walk_present/walk_ppn         walk completion from memory
//   flush                                   invalidate all entries
//   dirty_vec                               per-entry dirty bits
// Optional: define TLB_STATS_EN to add saturating hit_count/miss_count outputs.
module tlb_walker
  import vm_pkg::*;
#(
  parameter int unsigned VPN_W   = VPN_W_DEF,
  parameter int unsigned PPN_W   = PPN_W_DEF,
  parameter int unsigned ENTRIES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [VPN_W-1:0]   req_vpn,
  input  logic               req_write,
  input  logic               flush,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [PPN_W-1:0]   resp_ppn,
  output logic               resp_hit,
  output logic               page_fault,
  output logic               walk_req,
  output logic [VPN_W-1:0]   walk_vpn,
  input  logic               walk_done,
  input  logic               walk_present,
  input  logic [PPN_W-1:0]   walk_ppn,
  output logic [ENTRIES-1:0] dirty_vec
`ifdef TLB_STATS_EN
  ,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
`endif
);

  localparam int unsigned AGE_W = $clog2(ENTRIES);

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [VPN_W-1:0] tag;
    logic [PPN_W-1:0] ppn;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           pte_q [ENTRIES];
  entry_t           pte_d [ENTRIES];
  logic             resp_valid_q, resp_valid_d;
  logic             resp_hit_q, resp_hit_d;
  logic             page_fault_q, page_fault_d;
  logic [PPN_W-1:0] resp_ppn_q, resp_ppn_d;
  logic             walk_req_q, walk_req_d;
  logic [VPN_W-1:0] walk_vpn_q, walk_vpn_d;
  logic             req_ready_q, req_ready_d;
  logic             write_q, write_d;
  logic             fault_q, fault_d;
  logic [PPN_W-1:0] ppn_lat_q, ppn_lat_d;

  logic               cam_hit;
  logic [AGE_W-1:0]   hit_idx;
  logic [AGE_W-1:0]   victim_idx;
  logic [ENTRIES-1:0] valid_vec;
  logic               accept_c, hit_c, walk_start_c;
  logic               upd_en;
  logic [AGE_W-1:0]   upd_idx;

  // Tag CAM; tags are unique so priority only matters for lint-stable output.
  always_comb begin
    cam_hit = 1'b0;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (pte_q[i].valid && (pte_q[i].tag == req_vpn)) begin
        cam_hit = 1'b1;
        hit_idx = AGE_W'(i);
      end
    end
  end

  always_comb begin
    valid_vec = '0;
    dirty_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_vec[i] = pte_q[i].valid;
      dirty_vec[i] = pte_q[i].dirty;
    end
  end

  // A flush in the request cycle turns a would-be hit into a miss.
  assign accept_c     = req_valid && req_ready_q && (state_q == IDLE);
  assign hit_c        = accept_c && cam_hit && !flush;
  assign walk_start_c = accept_c && !hit_c;

  // Next-state, entry update and registered-output logic.
  always_comb begin
    state_d      = state_q;
    pte_d        = pte_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = 1'b0;
    page_fault_d = 1'b0;
    resp_ppn_d   = resp_ppn_q;
    walk_req_d   = walk_req_q;
    walk_vpn_d   = walk_vpn_q;
    write_d      = write_q;
    fault_d      = fault_q;
    ppn_lat_d    = ppn_lat_q;
    upd_en       = 1'b0;
    upd_idx      = hit_idx;

    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pte_d[i].valid = 1'b0;
        pte_d[i].dirty = 1'b0;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (hit_c) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          resp_ppn_d   = pte_q[hit_idx].ppn;
          upd_en       = 1'b1;
          if (req_write) pte_d[hit_idx].dirty = 1'b1;
        end else if (walk_start_c) begin
          walk_vpn_d = req_vpn;
          walk_req_d = 1'b1;
          write_d    = req_write;
          state_d    = WALK;
        end
      end
      WALK: begin
        if (walk_done) begin
          walk_req_d = 1'b0;
          fault_d    = !walk_present;
          ppn_lat_d  = walk_present ? walk_ppn : '0;
          // Fill is applied after the flush clear so a mid-walk flush keeps it.
          if (walk_present) begin
            pte_d[victim_idx] = entry_t'{valid: 1'b1, dirty: write_q,
                                         tag: walk_vpn_q, ppn: walk_ppn};
            upd_en  = 1'b1;
            upd_idx = victim_idx;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid_d = 1'b1;
        page_fault_d = fault_q;
        resp_ppn_d   = ppn_lat_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE) && !resp_valid_d;
  end

  tlb_lru #(
    .ENTRIES (ENTRIES)
  ) u_lru (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .upd_en       (upd_en),
    .upd_idx      (upd_idx),
    .valid_vec    (valid_vec),
    .victim_idx_c (victim_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      page_fault_q <= 1'b0;
      resp_ppn_q   <= '0;
      walk_req_q   <= 1'b0;
      walk_vpn_q   <= '0;
      req_ready_q  <= 1'b1;
      write_q      <= 1'b0;
      fault_q      <= 1'b0;
      ppn_lat_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) pte_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      page_fault_q <= page_fault_d;
      resp_ppn_q   <= resp_ppn_d;
      walk_req_q   <= walk_req_d;
      walk_vpn_q   <= walk_vpn_d;
      req_ready_q  <= req_ready_d;
      write_q      <= write_d;
      fault_q      <= fault_d;
      ppn_lat_q    <= ppn_lat_d;
      pte_q        <= pte_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign page_fault = page_fault_q;
  assign resp_ppn   = resp_ppn_q;
  assign walk_req   = walk_req_q;
  assign walk_vpn   = walk_vpn_q;
  assign req_ready  = req_ready_q;

`ifdef TLB_STATS_EN
  // Saturating event counters; flush leaves them untouched.
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_c && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
    if (walk_start_c && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_tlb_walker.sv
// Directed self-checking bench for tlb_walker (default parameters, 4 entries).
module tb_tlb_walker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [5:0] req_vpn;
  logic       req_write;
  logic       flush;
  logic       req_ready;
  logic       resp_valid;
  logic [1:0] resp_ppn;
  logic       resp_hit;
  logic       page_fault;
  logic       walk_req;
  logic [5:0] walk_vpn;
  logic       walk_done;
  logic       walk_present;
  logic [1:0] walk_ppn;
  logic [3:0] dirty_vec;
`ifdef TLB_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tlb_walker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_vpn      (req_vpn),
    .req_write    (req_write),
    .flush        (flush),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_ppn     (resp_ppn),
    .resp_hit     (resp_hit),
    .page_fault   (page_fault),
    .walk_req     (walk_req),
    .walk_vpn     (walk_vpn),
    .walk_done    (walk_done),
    .walk_present (walk_present),
    .walk_ppn     (walk_ppn),
    .dirty_vec    (dirty_vec)
`ifdef TLB_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_vpn = '0; req_write = 1'b0; flush = 1'b0;
    walk_done = 1'b0; walk_present = 1'b0; walk_ppn = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Issues one request and services the walk; returns what the DUT answered.
  // flush_wc: 0 = flush alongside the request, n>0 = flush in walk cycle n, <0 = none.
  task automatic translate(input logic [5:0] vpn, input logic wr, input int wlat,
                           input logic present, input logic [1:0] ppn, input int flush_wc,
                           output logic o_hit, output logic [1:0] o_ppn, output logic o_fault,
                           output int o_lat, output int o_wc, output logic [5:0] o_wvpn);
    o_hit = 1'b0; o_ppn = '0; o_fault = 1'b0; o_lat = -1; o_wc = 0; o_wvpn = '0;
    for (int k = 0; k < 20 && req_ready !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b1; req_vpn = vpn; req_write = wr;
    if (flush_wc == 0) flush = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      walk_done = 1'b0; flush = 1'b0;
      if (resp_valid === 1'b1) begin
        o_lat = c; o_hit = resp_hit; o_ppn = resp_ppn; o_fault = page_fault;
        break;
      end
      if (walk_req === 1'b1) begin
        o_wc++;
        if (o_wc == 1) o_wvpn = walk_vpn;
        if (o_wc == flush_wc) flush = 1'b1;
        if (o_wc == wlat) begin
          walk_done = 1'b1; walk_present = present; walk_ppn = ppn;
        end
      end
    end
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_vpn = '0; req_write = 1'b0; flush = 1'b0;
    walk_done = 1'b0; walk_present = 1'b0; walk_ppn = '0;
    @(posedge clk); #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    n_cmp++; if (resp_hit !== 1'b0) begin n_err++; $display("FAIL reset_resp_hit got=%b exp=0", resp_hit); end
    n_cmp++; if (page_fault !== 1'b0) begin n_err++; $display("FAIL reset_page_fault got=%b exp=0", page_fault); end
    n_cmp++; if (walk_req !== 1'b0) begin n_err++; $display("FAIL reset_walk_req got=%b exp=0", walk_req); end
    n_cmp++; if (resp_ppn !== 2'd0) begin n_err++; $display("FAIL reset_resp_ppn got=%0d exp=0", resp_ppn); end
    n_cmp++; if (walk_vpn !== 6'd0) begin n_err++; $display("FAIL reset_walk_vpn got=%0d exp=0", walk_vpn); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    n_cmp++; if (dirty_vec !== 4'b0000) begin n_err++; $display("FAIL reset_dirty_vec got=%b exp=0000", dirty_vec); end
`ifdef TLB_STATS_EN
    n_cmp++; if (hit_count !== 16'd0) begin n_err++; $display("FAIL reset_hit_count got=%0d exp=0", hit_count); end
    n_cmp++; if (miss_count !== 16'd0) begin n_err++; $display("FAIL reset_miss_count got=%0d exp=0", miss_count); end
`endif
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_walk();
    logic h, f; logic [1:0] p; int lat, wc; logic [5:0] wv;
    translate(6'h01, 1'b0, 3, 1'b1, 2'b10, -1, h, p, f, lat, wc, wv);
    n_cmp++; if (h !== 1'b0) begin n_err++; $display("FAIL walk_hit got=%b exp=0", h); end
    n_cmp++; if (p !== 2'd2) begin n_err++; $display("FAIL walk_ppn got=%0d exp=2", p); end
    n_cmp++; if (f !== 1'b0) begin n_err++; $display("FAIL walk_fault got=%b exp=0", f); end
    n_cmp++; if (wc != 3) begin n_err++; $display("FAIL walk_req_cycles got=%0d exp=3", wc); end
    n_cmp++; if (lat != 5) begin n_err++; $display("FAIL walk_latency got=%0d exp=5", lat); end
    n_cmp++; if (wv !== 6'h01) begin n_err++; $display("FAIL walk_vpn got=%0h exp=01", wv); end
    translate(6'h01, 1'b0, 3, 1'b1, 2'b00, -1, h, p, f, lat, wc, wv);
    n_cmp++; if (h !== 1'b1) begin n_err++; $display("FAIL rehit_hit got=%b exp=1", h); end
    n_cmp++; if (p !== 2'd2) begin n_err++; $display("FAIL rehit_ppn got=%0d exp=2", p); end
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL rehit_latency got=%0d exp=1", lat); end
    n_cmp++; if (wc != 0) begin n_err++; $display("FAIL rehit_walk_cycles got=%0d exp=0", wc); end
`ifdef TLB_STATS_EN
    n_cmp++; if (hit_count !== 16'd1) begin n_err++; $display("FAIL stats_hit_count got=%0d exp=1", hit_count); end
    n_cmp++; if (miss_count !== 16'd1) begin n_err++; $display("FAIL stats_miss_count got=%0d exp=1", miss_count); end
`endif
  endtask

  task automatic test_lru();
    logic h, f; logic [1:0] p; int lat, wc; logic [5:0] wv;
    // vpn, expect_hit pairs after filling 1..4 and touching 1 then missing on 5
    logic [5:0] seq_vpn [5] = '{6'd5, 6'd2, 6'd1, 6'd4, 6'd3};
    logic       seq_hit [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int v = 1; v <= 4; v++)
      translate(6'(v), 1'b0, 1, 1'b1, 2'(v), -1, h, p, f, lat, wc, wv);
    translate(6'd1, 1'b0, 1, 1'b1, 2'd0, -1, h, p, f, lat, wc, wv);
    n_cmp++; if (h !== 1'b1) begin n_err++; $display("FAIL lru_touch1_hit got=%b exp=1", h); end
    for (int s = 0; s < 5; s++) begin
      translate(seq_vpn[s], 1'b0, 1, 1'b1, 2'd3, -1, h, p, f, lat, wc, wv);
      n_cmp++;
      if (h !== seq_hit[s]) begin
        n_err++; $display("FAIL lru_seq%0d_vpn%0d_hit got=%b exp=%b", s, seq_vpn[s], h, seq_hit[s]);
      end
    end
    n_cmp++; if (dirty_vec !== 4'b0000) begin n_err++; $display("FAIL lru_dirty_vec got=%b exp=0000", dirty_vec); end
  endtask

  task automatic test_fault();
    logic h, f; logic [1:0] p; int lat, wc; logic [5:0] wv;
    do_reset();
    translate(6'h07, 1'b0, 2, 1'b0, 2'd3, -1, h, p, f, lat, wc, wv);
    n_cmp++; if (f !== 1'b1) begin n_err++; $display("FAIL fault_flag got=%b exp=1", f); end
    n_cmp++; if (p !== 2'd0) begin n_err++; $display("FAIL fault_ppn got=%0d exp=0", p); end
    n_cmp++; if (h !== 1'b0) begin n_err++; $display("FAIL fault_hit got=%b exp=0", h); end
    n_cmp++; if (lat != 4) begin n_err++; $display("FAIL fault_latency got=%0d exp=4", lat); end
    translate(6'h07, 1'b0, 2, 1'b1, 2'd1, -1, h, p, f, lat, wc, wv);
    n_cmp++; if (wc != 2) begin n_err++; $display("FAIL fault_retry_walks got=%0d exp=2", wc); end
    n_cmp++; if (f !== 1'b0) begin n_err++; $display("FAIL fault_retry_flag got=%b exp=0", f); end
    n_cmp++; if (p !== 2'd1) begin n_err++; $display("FAIL fault_retry_ppn got=%0d exp=1", p); end
  endtask

  task automatic test_dirty();
    logic h, f; logic [1:0] p; int lat, wc; logic [5:0] wv;
    do_reset();
    translate(6'd1, 1'b0, 1, 1'b1, 2'd1, -1, h, p, f, lat, wc, wv);
    translate(6'd3, 1'b0, 1, 1'b1, 2'd3, -1, h, p, f, lat, wc, wv);
    translate(6'd3, 1'b1, 1, 1'b1, 2'd0, -1, h, p, f, lat, wc, wv);
    n_cmp++; if (h !== 1'b1) begin n_err++; $display("FAIL dirty_store_hit got=%b exp=1", h); end
    n_cmp++; if (dirty_vec !== 4'b0010) begin n_err++; $display("FAIL dirty_store_vec got=%b exp=0010", dirty_vec); end
    translate(6'd1, 1'b0, 1, 1'b1, 2'd0, -1, h, p, f, lat, wc, wv);
    n_cmp++; if (p !== 2'd1) begin n_err++; $display("FAIL dirty_load_ppn got=%0d exp=1", p); end
    n_cmp++; if (dirty_vec !== 4'b0010) begin n_err++; $display("FAIL dirty_load_vec got=%b exp=0010", dirty_vec); end
    translate(6'd9, 1'b1, 1, 1'b1, 2'd2, -1, h, p, f, lat, wc, wv);
    n_cmp++; if (dirty_vec !== 4'b0110) begin n_err++; $display("FAIL dirty_store_fill_vec got=%b exp=0110", dirty_vec); end
  endtask

  task automatic test_flush();
    logic h, f; logic [1:0] p; int lat, wc; logic [5:0] wv;
    do_reset();
    for (int v = 1; v <= 4; v++)
      translate(6'(v), (v == 2) ? 1'b1 : 1'b0, 1, 1'b1, 2'(v), -1, h, p, f, lat, wc, wv);
    n_cmp++; if (dirty_vec !== 4'b0010) begin n_err++; $display("FAIL flush_pre_dirty got=%b exp=0010", dirty_vec); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++; if (dirty_vec !== 4'b0000) begin n_err++; $display("FAIL flush_dirty got=%b exp=0000", dirty_vec); end
    for (int v = 1; v <= 4; v++) begin
      translate(6'(v), 1'b0, 1, 1'b1, 2'(v), -1, h, p, f, lat, wc, wv);
      n_cmp++; if (h !== 1'b0) begin n_err++; $display("FAIL flush_miss_vpn%0d got=%b exp=0", v, h); end
    end
    translate(6'd8, 1'b0, 3, 1'b1, 2'd2, 2, h, p, f, lat, wc, wv);
    n_cmp++; if (p !== 2'd2) begin n_err++; $display("FAIL flush_walk_ppn got=%0d exp=2", p); end
    translate(6'd8, 1'b0, 1, 1'b1, 2'd0, -1, h, p, f, lat, wc, wv);
    n_cmp++; if (h !== 1'b1) begin n_err++; $display("FAIL flush_walk_fill_hit got=%b exp=1", h); end
    n_cmp++; if (p !== 2'd2) begin n_err++; $display("FAIL flush_walk_fill_ppn got=%0d exp=2", p); end
    translate(6'd1, 1'b0, 1, 1'b1, 2'd1, -1, h, p, f, lat, wc, wv);
    n_cmp++; if (h !== 1'b0) begin n_err++; $display("FAIL flush_walk_old_vpn1 got=%b exp=0", h); end
    // flush in the same cycle as a request that would hit: must walk instead
    translate(6'd8, 1'b0, 1, 1'b1, 2'd3, 0, h, p, f, lat, wc, wv);
    n_cmp++; if (h !== 1'b0) begin n_err++; $display("FAIL flush_same_cycle_hit got=%b exp=0", h); end
    n_cmp++; if (p !== 2'd3) begin n_err++; $display("FAIL flush_same_cycle_ppn got=%0d exp=3", p); end
  endtask

  task automatic test_reset_mid_walk();
    logic h, f; logic [1:0] p; int lat, wc; logic [5:0] wv;
    int seen_resp;
    do_reset();
    req_valid = 1'b1; req_vpn = 6'h20; req_write = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (walk_req !== 1'b1) begin n_err++; $display("FAIL rstwalk_walk_req_up got=%b exp=1", walk_req); end
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    n_cmp++; if (walk_req !== 1'b0) begin n_err++; $display("FAIL rstwalk_walk_req_drop got=%b exp=0", walk_req); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rstwalk_req_ready got=%b exp=1", req_ready); end
`ifdef TLB_STATS_EN
    n_cmp++; if (miss_count !== 16'd0) begin n_err++; $display("FAIL rstwalk_miss_count got=%0d exp=0", miss_count); end
    n_cmp++; if (hit_count !== 16'd0) begin n_err++; $display("FAIL rstwalk_hit_count got=%0d exp=0", hit_count); end
`endif
    seen_resp = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) rst_n = 1'b1;
      if (resp_valid !== 1'b0) seen_resp++;
    end
    n_cmp++; if (seen_resp != 0) begin n_err++; $display("FAIL rstwalk_no_resp got=%0d exp=0", seen_resp); end
    translate(6'h20, 1'b0, 1, 1'b1, 2'd1, -1, h, p, f, lat, wc, wv);
    n_cmp++; if (h !== 1'b0) begin n_err++; $display("FAIL rstwalk_no_fill got=%b exp=0", h); end
  endtask

  initial begin
    test_reset();
    test_basic_walk();
    test_lru();
    test_fault();
    test_dirty();
    test_flush();
    test_reset_mid_walk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
